// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared types and widths for the bootstrap copier
package boot_pkg;
  typedef enum logic [1:0] {PRIME, COPY, DONE} state_e;
  localparam int ROM_AW = 8;
  localparam int CPU_AW = 16;
  localparam int CNT_W  = ROM_AW + 1;
endpackage

// File: rtl/boot_copier.sv
// rtl/boot_copier.sv - copies LEN bytes of boot ROM into RAM at DEST_BASE, then releases the 6502
// Optional BOOT_CKSUM_EN adds a mod-256 checksum of the copied image and an error flag.
module boot_copier
  import boot_pkg::*;
#(
  parameter int                LEN       = 256,
  parameter logic [CPU_AW-1:0] DEST_BASE = 16'hFF00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [CPU_AW-1:0] ram_addr,
  output logic [7:0]        ram_dbw,
  output logic              ram_we,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done
`ifdef BOOT_CKSUM_EN
  ,
  output logic [7:0]        cksum,
  output logic              cksum_err
`endif
);

  localparam logic [CNT_W-1:0] LEN_C    = CNT_W'(LEN);
  localparam logic [CNT_W-1:0] LAST_RD  = CNT_W'(LEN - 1);
  localparam logic [CNT_W-1:0] FIRST_RD = (LEN > 1) ? CNT_W'(1) : CNT_W'(0);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [ROM_AW-1:0]  rom_addr_q, rom_addr_d;
  logic [CPU_AW-1:0]  ram_addr_q, ram_addr_d;
  logic [7:0]         ram_dbw_q, ram_dbw_d;
  logic               ram_we_q, ram_we_d;
  logic               hold_q, hold_d, busy_q, busy_d, done_q, done_d;
`ifdef BOOT_CKSUM_EN
  logic [7:0]         sum_q, sum_d;
  logic               err_q, err_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PRIME;
      rd_q       <= '0;
      wr_q       <= '0;
      rom_addr_q <= '0;
      ram_addr_q <= DEST_BASE;
      ram_dbw_q  <= '0;
      ram_we_q   <= 1'b0;
      hold_q     <= 1'b1;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
`ifdef BOOT_CKSUM_EN
      sum_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      rom_addr_q <= rom_addr_d;
      ram_addr_q <= ram_addr_d;
      ram_dbw_q  <= ram_dbw_d;
      ram_we_q   <= ram_we_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef BOOT_CKSUM_EN
      sum_q      <= sum_d;
      err_q      <= err_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    rom_addr_d = rom_addr_q;
    ram_addr_d = ram_addr_q;
    ram_dbw_d  = ram_dbw_q;
    ram_we_d   = ram_we_q;
    hold_d     = hold_q;
    busy_d     = busy_q;
    done_d     = done_q;
`ifdef BOOT_CKSUM_EN
    sum_d      = sum_q;
    err_d      = err_q;
`endif
    case (state_q)
      PRIME: begin
        // ROM is sampling address 0 on this edge; point at byte 1 for the next one
        rd_d       = FIRST_RD;
        rom_addr_d = FIRST_RD[ROM_AW-1:0];
        wr_d       = '0;
        state_d    = COPY;
`ifdef BOOT_CKSUM_EN
        sum_d      = '0;
        err_d      = 1'b0;
`endif
      end
      COPY: begin
        if (rd_q < LAST_RD) begin
          rd_d       = rd_q + CNT_W'(1);
          rom_addr_d = rd_d[ROM_AW-1:0];
        end
        if (wr_q == LEN_C) begin
          ram_we_d = 1'b0;
          hold_d   = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = DONE;
`ifdef BOOT_CKSUM_EN
          err_d    = (sum_q != 8'd0);
`endif
        end else begin
          ram_we_d   = 1'b1;
          ram_addr_d = DEST_BASE + CPU_AW'(wr_q);
          ram_dbw_d  = rom_data;
          wr_d       = wr_q + CNT_W'(1);
`ifdef BOOT_CKSUM_EN
          sum_d      = sum_q + rom_data;
`endif
        end
      end
      DONE: begin
        if (start) begin
          state_d    = PRIME;
          rom_addr_d = '0;
          ram_we_d   = 1'b0;
          hold_d     = 1'b1;
          busy_d     = 1'b1;
          done_d     = 1'b0;
`ifdef BOOT_CKSUM_EN
          err_d      = 1'b0;
`endif
        end
      end
      default: state_d = PRIME;
    endcase
  end

  assign rom_addr  = rom_addr_q;
  assign ram_addr  = ram_addr_q;
  assign ram_dbw   = ram_dbw_q;
  assign ram_we    = ram_we_q;
  assign cpu_hold  = hold_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef BOOT_CKSUM_EN
  assign cksum     = sum_q;
  assign cksum_err = err_q;
`endif

endmodule

// File: tb/tb_boot_copier.sv
// tb/tb_boot_copier.sv - scoreboard bench for boot_copier: three instances (LEN 256, 16, 1)
module tb_boot_copier;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0;
  logic start_z = 1'b0;

  logic [7:0]  rom_a [256];
  logic [7:0]  rom_addr_a, rom_data_a, ram_dbw_a;
  logic [15:0] ram_addr_a;
  logic        ram_we_a, hold_a, busy_a, done_a;
  logic [7:0]  rom_addr_b, rom_data_b, ram_dbw_b;
  logic [15:0] ram_addr_b;
  logic        ram_we_b, hold_b, busy_b, done_b;
  logic [7:0]  rom_addr_c, rom_data_c, ram_dbw_c;
  logic [15:0] ram_addr_c;
  logic        ram_we_c, hold_c, busy_c, done_c;
`ifdef BOOT_CKSUM_EN
  logic [7:0]  cksum_a, cksum_b, cksum_c;
  logic        err_a, err_b, err_c;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_data_a <= rom_a[rom_addr_a];
    rom_data_b <= rom_addr_b ^ 8'hA5;
    rom_data_c <= rom_addr_c ^ 8'hA5;
  end

  boot_copier u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .rom_addr(rom_addr_a), .rom_data(rom_data_a),
    .ram_addr(ram_addr_a), .ram_dbw(ram_dbw_a), .ram_we(ram_we_a),
    .cpu_hold(hold_a), .busy(busy_a), .done(done_a)
`ifdef BOOT_CKSUM_EN
    , .cksum(cksum_a), .cksum_err(err_a)
`endif
  );

  boot_copier #(.LEN(16), .DEST_BASE(16'h0200)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_z),
    .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .ram_addr(ram_addr_b), .ram_dbw(ram_dbw_b), .ram_we(ram_we_b),
    .cpu_hold(hold_b), .busy(busy_b), .done(done_b)
`ifdef BOOT_CKSUM_EN
    , .cksum(cksum_b), .cksum_err(err_b)
`endif
  );

  boot_copier #(.LEN(1), .DEST_BASE(16'h1234)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_z),
    .rom_addr(rom_addr_c), .rom_data(rom_data_c),
    .ram_addr(ram_addr_c), .ram_dbw(ram_dbw_c), .ram_we(ram_we_c),
    .cpu_hold(hold_c), .busy(busy_c), .done(done_c)
`ifdef BOOT_CKSUM_EN
    , .cksum(cksum_c), .cksum_err(err_c)
`endif
  );

  int n_checks = 0;
  int n_fail = 0;
  int edge_n, we_a, we_b, we_c, de_a, de_b, de_c, runs_b, max_rom_b;
  logic prev_we_b;
  logic [23:0] q_a[$], q_b[$], q_c[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_a();
    for (int i = 0; i < 256; i++) q_a.push_back({16'hFF00 + 16'(i), rom_a[i]});
  endtask

  task automatic push_bc();
    for (int i = 0; i < 16; i++) q_b.push_back({16'h0200 + 16'(i), 8'(i) ^ 8'hA5});
    q_c.push_back({16'h1234, 8'hA5});
  endtask

  task automatic clear_stats();
    edge_n = 0; we_a = 0; we_b = 0; we_c = 0;
    de_a = 0; de_b = 0; de_c = 0; runs_b = 0; max_rom_b = 0; prev_we_b = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    edge_n++;
    if (ram_we_a) begin
      if (q_a.size() == 0) chk("a_unexpected_write", {8'h0, ram_addr_a, ram_dbw_a}, 32'hFFFFFFFF);
      else chk("a_write", {8'h0, ram_addr_a, ram_dbw_a}, {8'h0, q_a.pop_front()});
      we_a++;
    end
    if (ram_we_b) begin
      if (q_b.size() == 0) chk("b_unexpected_write", {8'h0, ram_addr_b, ram_dbw_b}, 32'hFFFFFFFF);
      else chk("b_write", {8'h0, ram_addr_b, ram_dbw_b}, {8'h0, q_b.pop_front()});
      we_b++;
      if (!prev_we_b) runs_b++;
    end
    prev_we_b = ram_we_b;
    if (ram_we_c) begin
      if (q_c.size() == 0) chk("c_unexpected_write", {8'h0, ram_addr_c, ram_dbw_c}, 32'hFFFFFFFF);
      else chk("c_write", {8'h0, ram_addr_c, ram_dbw_c}, {8'h0, q_c.pop_front()});
      we_c++;
    end
    if (int'(rom_addr_b) > max_rom_b) max_rom_b = int'(rom_addr_b);
    if (done_a && de_a == 0) de_a = edge_n;
    if (done_b && de_b == 0) de_b = edge_n;
    if (done_c && de_c == 0) de_c = edge_n;
  endtask

  task automatic restart_a(input int exp_done_edge, input string tag);
    push_a();
    clear_stats();
    start_a = 1'b1;
    cycle();
    start_a = 1'b0;
    chk({tag, "_hold_after_start"}, 32'(hold_a), 32'd1);
    chk({tag, "_busy_after_start"}, 32'(busy_a), 32'd1);
    chk({tag, "_done_after_start"}, 32'(done_a), 32'd0);
    chk({tag, "_rom_addr_after_start"}, 32'(rom_addr_a), 32'd0);
    repeat (262) cycle();
    chk({tag, "_done_edge"}, 32'(de_a), 32'(exp_done_edge));
    chk({tag, "_write_count"}, 32'(we_a), 32'd256);
    chk({tag, "_queue_left"}, 32'(q_a.size()), 32'd0);
    chk({tag, "_hold_released"}, 32'(hold_a), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom_a[i] = 8'(i) ^ 8'hA5;
    clear_stats();
    repeat (2) @(negedge clk);
    chk("rst_rom_addr", 32'(rom_addr_a), 32'd0);
    chk("rst_ram_addr_a", 32'(ram_addr_a), 32'hFF00);
    chk("rst_ram_addr_b", 32'(ram_addr_b), 32'h0200);
    chk("rst_ram_dbw", 32'(ram_dbw_a), 32'd0);
    chk("rst_ram_we", 32'(ram_we_a), 32'd0);
    chk("rst_cpu_hold", 32'(hold_a), 32'd1);
    chk("rst_busy", 32'(busy_a), 32'd1);
    chk("rst_done", 32'(done_a), 32'd0);

    // Power-on copy; a start pulse while busy must be ignored
    push_a();
    push_bc();
    rst_n = 1'b1;
    for (int n = 0; n < 262; n++) begin
      cycle();
      start_a = (edge_n == 100);
      if (edge_n == 257) chk("a_hold_before_done", 32'(hold_a), 32'd1);
    end
    start_a = 1'b0;
    chk("a_done_edge", 32'(de_a), 32'd258);
    chk("a_write_count", 32'(we_a), 32'd256);
    chk("a_queue_left", 32'(q_a.size()), 32'd0);
    chk("a_hold_released", 32'(hold_a), 32'd0);
    chk("a_busy_clear", 32'(busy_a), 32'd0);
    chk("b_done_edge", 32'(de_b), 32'd18);
    chk("b_write_count", 32'(we_b), 32'd16);
    chk("b_we_runs", 32'(runs_b), 32'd1);
    chk("b_max_rom_addr", 32'(max_rom_b), 32'd15);
    chk("b_queue_left", 32'(q_b.size()), 32'd0);
    chk("c_done_edge", 32'(de_c), 32'd3);
    chk("c_write_count", 32'(we_c), 32'd1);
    chk("c_rom_addr", 32'(rom_addr_c), 32'd0);

    // Soft reboot: the start edge plays the role of reset release, so done lands one edge later
    restart_a(259, "reboot");

    // Reset during write 57
    push_a();
    clear_stats();
    start_a = 1'b1;
    cycle();
    start_a = 1'b0;
    for (int n = 0; n < 300 && we_a < 58; n++) cycle();
    chk("mid_reached_write57", 32'(we_a), 32'd58);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_ram_we_async", 32'(ram_we_a), 32'd0);
    chk("mid_hold", 32'(hold_a), 32'd1);
    chk("mid_rom_addr", 32'(rom_addr_a), 32'd0);
    q_a.delete();
    q_b.delete();
    q_c.delete();
    push_a();
    push_bc();
    clear_stats();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (262) cycle();
    chk("mid_done_edge", 32'(de_a), 32'd258);
    chk("mid_write_count", 32'(we_a), 32'd256);
    chk("mid_queue_left", 32'(q_a.size()), 32'd0);
    chk("mid_b_write_count", 32'(we_b), 32'd16);
    chk("mid_c_done_edge", 32'(de_c), 32'd3);

`ifdef BOOT_CKSUM_EN
    begin
      logic [7:0] s;
      s = 8'd0;
      for (int i = 0; i < 255; i++) s = s + rom_a[i];
      rom_a[255] = 8'd0 - s;
      restart_a(259, "ck_good");
      s = 8'd0;
      for (int i = 0; i < 256; i++) s = s + rom_a[i];
      chk("ck_good_sum", 32'(cksum_a), 32'(s));
      chk("ck_good_err", 32'(err_a), 32'(s != 8'd0));
      rom_a[10] = rom_a[10] + 8'd1;
      restart_a(259, "ck_bad");
      s = 8'd0;
      for (int i = 0; i < 256; i++) s = s + rom_a[i];
      chk("ck_bad_sum", 32'(cksum_a), 32'(s));
      chk("ck_bad_err", 32'(err_a), 32'(s != 8'd0));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
